// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, write-back data cache controller.
package dcache_pkg;

  localparam int TAG_W     = 23;
  localparam int IDX_W     = 4;
  localparam int LINE_W    = 256;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;
  localparam int OFFSET_W  = 5;

  localparam int WORD_W    = 32;
  localparam int WORDS     = LINE_W / WORD_W;
  localparam int WSEL_W    = 3;
  localparam int STAG_W    = TAG_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_READMISS,
    S_READMISSOK
  } state_e;

  // CPU byte address split into cache fields
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [1:0]        boff;
  } cpu_addr_t;

  // Tag-store entry layout
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } stag_t;

  // Line-aligned memory address from a tag and index
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Word select and word replace on one cache line; purely combinational.
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] word_idx_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] word_o
);

  logic [WORDS-1:0][WORD_W-1:0] words_in;
  logic [WORDS-1:0][WORD_W-1:0] words_out;

  assign words_in = line_i;
  assign word_o   = words_in[word_idx_i];

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign words_out[w] = (word_idx_i == WSEL_W'(w)) ? word_i : words_in[w];
  end

  assign line_o = words_out;

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back cache controller: serves hits from the tag store in the
// same cycle, and on a miss writes back a dirty victim then fills the line from memory.
// CPU inputs are held by the CPU while stalled, so only the FSM state is registered.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              sram_enable_o,
  output logic [IDX_W-1:0]  sram_addr_o,
  output logic [STAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_write_o,
  input  logic              sram_hit_i,
  input  logic [STAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i
);

  state_e            state_q, state_d;
  cpu_addr_t         req;
  stag_t             victim;
  logic [LINE_W-1:0] merged_line;
  logic [WORD_W-1:0] rd_word;
  logic              unused_boff;

  assign req         = cpu_addr_i;
  assign victim      = sram_tag_i;
  assign unused_boff = ^req.boff;

  dcache_word_merge u_merge (
    .line_i     (sram_data_i),
    .word_idx_i (req.word),
    .word_i     (cpu_data_i),
    .line_o     (merged_line),
    .word_o     (rd_word)
  );

  // State register; reset returns to IDLE from anywhere, abandoning any handshake
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and outputs; everything is held at zero while reset is asserted
  always_comb begin
    state_d       = state_q;
    cpu_data_o    = '0;
    cpu_stall_o   = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;
    sram_enable_o = 1'b0;
    sram_addr_o   = '0;
    sram_tag_o    = '0;
    sram_data_o   = '0;
    sram_write_o  = 1'b0;
    if (rst_i) begin
      // the tag store stays addressed at the request index so the victim stays visible
      sram_addr_o   = req.idx;
      sram_enable_o = 1'b1;
      cpu_stall_o   = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          sram_enable_o = cpu_req_i;
          cpu_stall_o   = 1'b0;
          if (cpu_req_i) begin
            if (!sram_hit_i) begin
              cpu_stall_o = 1'b1;
              state_d     = S_MISS;
            end else if (cpu_MemWrite_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = merged_line;
              sram_tag_o   = {1'b1, 1'b1, req.tag};
            end else begin
              cpu_data_o = rd_word;
            end
          end
        end
        S_MISS: begin
          if (victim.valid && victim.dirty) state_d = S_WRITEBACK;
          else                              state_d = S_READMISS;
        end
        S_WRITEBACK: begin
          mem_enable_o = 1'b1;
          mem_write_o  = 1'b1;
          mem_addr_o   = line_addr(victim.tag, req.idx);
          mem_data_o   = sram_data_i;
          if (mem_ack_i) state_d = S_READMISS;
        end
        S_READMISS: begin
          mem_enable_o = 1'b1;
          mem_addr_o   = line_addr(req.tag, req.idx);
          if (mem_ack_i) begin
            sram_write_o = 1'b1;
            sram_data_o  = mem_data_i;
            sram_tag_o   = {1'b1, 1'b0, req.tag};
            state_d      = S_READMISSOK;
          end
        end
        S_READMISSOK: state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: tag store and memory are modelled here; a flat golden
// memory plus a per-index directory predicts hits, stall lengths and memory traffic.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_MemWrite_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         sram_enable_o, sram_write_o, sram_hit_i;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;

  int n_cmp, n_err;
  int cyc = 0;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_MemWrite_i(cpu_MemWrite_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .sram_enable_o(sram_enable_o), .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
    .sram_data_o(sram_data_o), .sram_write_o(sram_write_o), .sram_hit_i(sram_hit_i),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- tag store model ----------------
  logic [24:0]  tag_arr  [0:15] = '{default: '0};
  logic [255:0] data_arr [0:15] = '{default: '0};
  logic         pl_en;
  logic [3:0]   pl_idx;
  logic [24:0]  pl_tag;
  logic [255:0] pl_data;

  assign sram_tag_i  = tag_arr[sram_addr_o];
  assign sram_data_i = data_arr[sram_addr_o];
  assign sram_hit_i  = tag_arr[sram_addr_o][24] && (tag_arr[sram_addr_o][22:0] == cpu_addr_i[31:9]);

  always @(posedge clk_i) begin
    if (pl_en) begin
      tag_arr[pl_idx]  <= pl_tag;
      data_arr[pl_idx] <= pl_data;
    end else if (sram_write_o) begin
      tag_arr[sram_addr_o]  <= sram_tag_o;
      data_arr[sram_addr_o] <= sram_data_o;
    end
  end

  // ---------------- memory model ----------------
  logic [255:0] mem_line [logic [31:0]];
  int           mem_lat, stray_tok;
  int           wb_cnt, rd_cnt, hold_viol, ack_cyc;
  logic [31:0]  last_wb_addr, last_rd_addr;
  logic [255:0] last_wb_data;

  function automatic logic [255:0] mem_init(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w*4)) ^ 32'h5A5A_0F0F;
    return l;
  endfunction

  function automatic logic [255:0] mem_get(input logic [31:0] la);
    if (mem_line.exists(la)) return mem_line[la];
    return mem_init(la);
  endfunction

  // responder: acks each transaction mem_lat cycles after it is first seen
  initial begin
    int          wcnt, seen_tok;
    logic        act, w0;
    logic [31:0] a0;
    logic [255:0] d0;
    mem_ack_i = 1'b0; mem_data_i = '0; wcnt = 0; seen_tok = 0; act = 1'b0;
    w0 = 1'b0; a0 = '0; d0 = '0;
    wb_cnt = 0; rd_cnt = 0; hold_viol = 0; ack_cyc = 0;
    last_wb_addr = '0; last_rd_addr = '0; last_wb_data = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (stray_tok != seen_tok) begin
        seen_tok  = stray_tok;
        mem_ack_i = 1'b1;
      end else if (mem_enable_o) begin
        if (!act) begin
          act = 1'b1; a0 = mem_addr_o; w0 = mem_write_o; d0 = mem_data_o; wcnt = 0;
        end else if (mem_addr_o !== a0 || mem_write_o !== w0 || (w0 && mem_data_o !== d0)) begin
          hold_viol++;
        end
        if (wcnt >= mem_lat) begin
          mem_ack_i = 1'b1; ack_cyc = cyc; act = 1'b0;
          if (w0) begin
            mem_line[a0] = d0; wb_cnt++; last_wb_addr = a0; last_wb_data = d0;
          end else begin
            mem_data_i = mem_get(a0); rd_cnt++; last_rd_addr = a0;
          end
        end else wcnt++;
      end else act = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic         ref_v [16];
  logic         ref_d [16];
  logic [22:0]  ref_t [16];
  logic [255:0] golden [logic [31:0]];

  function automatic logic [255:0] gold_get(input logic [31:0] la);
    if (golden.exists(la)) return golden[la];
    return mem_init(la);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic preload(input logic [3:0] i, input logic [24:0] t, input logic [255:0] d);
    @(negedge clk_i);
    pl_idx = i; pl_tag = t; pl_data = d; pl_en = 1'b1;
    @(posedge clk_i); #1;
    pl_en = 1'b0;
  endtask

  // one CPU access, held until the stall drops; reports what was seen
  task automatic cpu_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stalls, output logic mem_seen,
                        output logic wr_seen, output int rel_cyc, output logic timeout);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_MemWrite_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
    stalls = 0; mem_seen = 1'b0; timeout = 1'b0;
    #1;
    while (cpu_stall_o === 1'b1 && !timeout) begin
      if (mem_enable_o) mem_seen = 1'b1;
      stalls++;
      if (stalls > 300) timeout = 1'b1;
      @(negedge clk_i); #1;
    end
    if (mem_enable_o) mem_seen = 1'b1;
    rdata = cpu_data_o; wr_seen = sram_write_o; rel_cyc = cyc;
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_MemWrite_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_MemWrite_i = 1'b1; cpu_addr_i = $urandom; cpu_data_i = $urandom;
    #1;
    n_cmp++; if ({cpu_stall_o, mem_enable_o, mem_write_o, sram_write_o, sram_enable_o} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 00000", {cpu_stall_o, mem_enable_o, mem_write_o, sram_write_o, sram_enable_o}); end
    n_cmp++; if ({cpu_data_o, mem_addr_o, sram_addr_o} !== 68'b0) begin
      n_err++; $display("FAIL reset_addr: got %h %h %h expected 0", cpu_data_o, mem_addr_o, sram_addr_o); end
    n_cmp++; if ({mem_data_o, sram_data_o, sram_tag_o} !== 537'b0) begin
      n_err++; $display("FAIL reset_bus: got tag %h expected 0", sram_tag_o); end
    @(negedge clk_i);
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_MemWrite_i = 1'b0;
  endtask

  task automatic test_read_hit;
    logic [255:0] l; logic [31:0] rd; int st, rc; logic ms, ws, to;
    l = rand_line(); l[3*32 +: 32] = 32'hDEADBEEF;
    preload(4'd3, {2'b10, 23'h0}, l);
    cpu_op(1'b0, 32'h0000_006C, 32'h0, rd, st, ms, ws, rc, to);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rdhit_data: got %h expected DEADBEEF", rd); end
    n_cmp++; if (st !== 0) begin n_err++; $display("FAIL rdhit_stall: got %0d expected 0", st); end
    n_cmp++; if ({ms, ws} !== 2'b00) begin n_err++; $display("FAIL rdhit_side: got mem/wr %b expected 00", {ms, ws}); end
  endtask

  task automatic test_write_hit;
    logic [255:0] l, e; logic [31:0] rd; int st, rc; logic ms, ws, to;
    l = rand_line(); e = l; e[31:0] = 32'h1234_5678;
    preload(4'd1, {2'b10, 23'h0}, l);
    cpu_op(1'b1, 32'h0000_0020, 32'h1234_5678, rd, st, ms, ws, rc, to);
    n_cmp++; if ({ws, st != 0, ms} !== 3'b100) begin n_err++; $display("FAIL wrhit_pulse: got wr %b stall %0d mem %b expected wr 1 stall 0 mem 0", ws, st, ms); end
    n_cmp++; if (data_arr[1] !== e) begin n_err++; $display("FAIL wrhit_line: got %h expected %h", data_arr[1], e); end
    n_cmp++; if (tag_arr[1] !== {2'b11, 23'h0}) begin n_err++; $display("FAIL wrhit_tag: got %h expected %h", tag_arr[1], {2'b11, 23'h0}); end
  endtask

  task automatic test_clean_miss;
    logic [31:0] la, rd; logic [255:0] ml; int st, rc, wb0, rd0; logic ms, ws, to;
    la = {23'h55, 4'd5, 5'd0}; ml = mem_get(la);
    preload(4'd5, {2'b01, 23'h7A5A5}, rand_line());
    mem_lat = 10; wb0 = wb_cnt; rd0 = rd_cnt;
    cpu_op(1'b0, la | 32'h8, 32'h0, rd, st, ms, ws, rc, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL clean_timeout: stall never released"); end
    n_cmp++; if (st !== 14) begin n_err++; $display("FAIL clean_stall: got %0d expected 14", st); end
    n_cmp++; if (wb_cnt - wb0 !== 0 || rd_cnt - rd0 !== 1) begin
      n_err++; $display("FAIL clean_txn: got wb %0d rd %0d expected wb 0 rd 1", wb_cnt - wb0, rd_cnt - rd0); end
    n_cmp++; if (last_rd_addr !== la) begin n_err++; $display("FAIL clean_addr: got %h expected %h", last_rd_addr, la); end
    n_cmp++; if (rc - ack_cyc !== 2) begin n_err++; $display("FAIL clean_release: got %0d expected 2 cycles after ack", rc - ack_cyc); end
    n_cmp++; if (tag_arr[5] !== {2'b10, 23'h55}) begin n_err++; $display("FAIL clean_tag: got %h expected %h", tag_arr[5], {2'b10, 23'h55}); end
    n_cmp++; if (rd !== ml[2*32 +: 32] || data_arr[5] !== ml) begin n_err++; $display("FAIL clean_data: got %h expected %h", rd, ml[2*32 +: 32]); end
    mem_lat = 0;
  endtask

  task automatic test_dirty_miss;
    logic [31:0] la, rd; logic [255:0] v, ml; int st, rc, wb0, rd0; logic ms, ws, to;
    la = {23'h2, 4'd2, 5'd0}; ml = mem_get(la); v = rand_line();
    preload(4'd2, {2'b11, 23'h1}, v);
    mem_lat = 2; wb0 = wb_cnt; rd0 = rd_cnt;
    cpu_op(1'b0, la | 32'h4, 32'h0, rd, st, ms, ws, rc, to);
    n_cmp++; if (st !== 9 || to) begin n_err++; $display("FAIL dirty_stall: got %0d expected 9", st); end
    n_cmp++; if (wb_cnt - wb0 !== 1 || rd_cnt - rd0 !== 1) begin
      n_err++; $display("FAIL dirty_txn: got wb %0d rd %0d expected wb 1 rd 1", wb_cnt - wb0, rd_cnt - rd0); end
    n_cmp++; if (last_wb_addr !== 32'h0000_0240) begin n_err++; $display("FAIL dirty_wbaddr: got %h expected 00000240", last_wb_addr); end
    n_cmp++; if (last_wb_data !== v) begin n_err++; $display("FAIL dirty_wbdata: got %h expected %h", last_wb_data, v); end
    n_cmp++; if (last_rd_addr !== la || rd !== ml[63:32]) begin n_err++; $display("FAIL dirty_fill: got addr %h data %h expected %h %h", last_rd_addr, rd, la, ml[63:32]); end
    mem_lat = 0;
  endtask

  task automatic test_req_drop;
    int rd0; logic rel;
    preload(4'd9, 25'h0, 256'h0);
    mem_lat = 3; rd0 = rd_cnt; rel = 1'b0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_MemWrite_i = 1'b0; cpu_addr_i = {23'h7, 4'd9, 3'd4, 2'b0};
    repeat (2) @(negedge clk_i);
    #1 cpu_req_i = 1'b0;
    for (int i = 0; i < 40 && !rel; i++) begin @(negedge clk_i); #1; if (!cpu_stall_o) rel = 1'b1; end
    n_cmp++; if (!rel) begin n_err++; $display("FAIL drop_release: stall still 1 after 40 cycles"); end
    n_cmp++; if (rd_cnt - rd0 !== 1) begin n_err++; $display("FAIL drop_fill: got %0d reads expected 1", rd_cnt - rd0); end
    n_cmp++; if (tag_arr[9] !== {2'b10, 23'h7}) begin n_err++; $display("FAIL drop_tag: got %h expected %h", tag_arr[9], {2'b10, 23'h7}); end
    mem_lat = 0;
  endtask

  task automatic test_reset_mid_wb;
    logic got; int wb0, rd0;
    preload(4'd7, {2'b11, 23'h3}, rand_line());
    mem_lat = 20; wb0 = wb_cnt; rd0 = rd_cnt; got = 1'b0;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_MemWrite_i = 1'b0; cpu_addr_i = {23'h4, 4'd7, 5'd0};
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk_i); #1; if (mem_enable_o && mem_write_o) got = 1'b1; end
    n_cmp++; if (!got) begin n_err++; $display("FAIL rstwb_enter: writeback never started"); end
    rst_i = 1'b0; #1;
    n_cmp++; if ({mem_enable_o, mem_write_o, cpu_stall_o, sram_write_o} !== 4'b0) begin
      n_err++; $display("FAIL rstwb_outs: got %b expected 0000", {mem_enable_o, mem_write_o, cpu_stall_o, sram_write_o}); end
    @(negedge clk_i);
    rst_i = 1'b1; cpu_req_i = 1'b0; #1;
    n_cmp++; if ({cpu_stall_o, mem_enable_o} !== 2'b0) begin n_err++; $display("FAIL rstwb_idle: got stall/en %b expected 00", {cpu_stall_o, mem_enable_o}); end
    stray_tok++;
    @(negedge clk_i); #1;
    n_cmp++; if ({sram_write_o, mem_enable_o, cpu_stall_o} !== 3'b0) begin
      n_err++; $display("FAIL rstwb_lateack: got %b expected 000", {sram_write_o, mem_enable_o, cpu_stall_o}); end
    @(posedge clk_i); #1;
    n_cmp++; if (tag_arr[7] !== {2'b11, 23'h3} || wb_cnt != wb0 || rd_cnt != rd0) begin
      n_err++; $display("FAIL rstwb_state: got tag %h wb %0d rd %0d expected %h 0 0", tag_arr[7], wb_cnt - wb0, rd_cnt - rd0, {2'b11, 23'h3}); end
    mem_lat = 0;
  endtask

  task automatic test_stray_ack;
    @(negedge clk_i);
    cpu_req_i = 1'b0; cpu_MemWrite_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    #1 stray_tok++;
    @(negedge clk_i); #1;
    n_cmp++; if ({cpu_stall_o, mem_enable_o, mem_write_o, sram_write_o, sram_enable_o} !== 5'b0) begin
      n_err++; $display("FAIL stray_ctrl: got %b expected 00000", {cpu_stall_o, mem_enable_o, mem_write_o, sram_write_o, sram_enable_o}); end
    n_cmp++; if ({cpu_data_o, mem_addr_o, sram_addr_o, sram_tag_o} !== 93'b0) begin
      n_err++; $display("FAIL stray_bus: got data %h addr %h expected 0", cpu_data_o, mem_addr_o); end
    @(negedge clk_i); #1;
    n_cmp++; if ({cpu_stall_o, mem_enable_o} !== 2'b0) begin n_err++; $display("FAIL stray_after: got %b expected 00", {cpu_stall_o, mem_enable_o}); end
  endtask

  task automatic test_random;
    logic [31:0] addr, wd, rd, la, va; logic [22:0] tag; logic [3:0] idx; logic [2:0] ws3;
    logic wr, hit, dirty, ms, wsn, to; logic [255:0] gl, vl; int st, est, wb0, rd0, rc;
    for (int i = 0; i < 16; i++) begin preload(4'(i), 25'h0, 256'h0); ref_v[i] = 1'b0; ref_d[i] = 1'b0; ref_t[i] = '0; end
    for (int n = 0; n < 80; n++) begin
      tag = 23'h100 + 23'($urandom_range(0, 3)); idx = 4'($urandom_range(0, 3)); ws3 = 3'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1)); wd = $urandom; mem_lat = $urandom_range(0, 4);
      addr = {tag, idx, ws3, 2'($urandom_range(0, 3))}; la = {tag, idx, 5'd0};
      hit = ref_v[idx] && ref_t[idx] == tag;
      dirty = !hit && ref_v[idx] && ref_d[idx];
      va = {ref_t[idx], idx, 5'd0}; vl = gold_get(va);
      est = hit ? 0 : 3 + (mem_lat + 1) + (dirty ? mem_lat + 1 : 0);
      wb0 = wb_cnt; rd0 = rd_cnt;
      cpu_op(wr, addr, wd, rd, st, ms, wsn, rc, to);
      gl = gold_get(la);
      n_cmp++; if (st !== est || to) begin n_err++; $display("FAIL rnd_stall[%0d]: got %0d expected %0d", n, st, est); end
      n_cmp++; if (wb_cnt - wb0 !== (dirty ? 1 : 0) || rd_cnt - rd0 !== (hit ? 0 : 1)) begin
        n_err++; $display("FAIL rnd_txn[%0d]: got wb %0d rd %0d expected wb %0d rd %0d", n, wb_cnt - wb0, rd_cnt - rd0, dirty, !hit); end
      if (dirty) begin
        n_cmp++; if (last_wb_addr !== va || last_wb_data !== vl) begin
          n_err++; $display("FAIL rnd_wb[%0d]: got addr %h expected %h", n, last_wb_addr, va); end
      end
      if (!hit) begin
        n_cmp++; if (last_rd_addr !== la) begin n_err++; $display("FAIL rnd_rdaddr[%0d]: got %h expected %h", n, last_rd_addr, la); end
      end
      if (wr) begin
        n_cmp++; if (wsn !== 1'b1) begin n_err++; $display("FAIL rnd_wrpulse[%0d]: got %b expected 1", n, wsn); end
        gl[ws3*32 +: 32] = wd; golden[la] = gl;
      end else begin
        n_cmp++; if (rd !== gl[ws3*32 +: 32] || wsn !== 1'b0) begin
          n_err++; $display("FAIL rnd_read[%0d]: got %h wr %b expected %h wr 0", n, rd, wsn, gl[ws3*32 +: 32]); end
      end
      if (!hit) begin ref_v[idx] = 1'b1; ref_t[idx] = tag; ref_d[idx] = 1'b0; end
      if (wr) ref_d[idx] = 1'b1;
      n_cmp++; if (tag_arr[idx] !== {1'b1, ref_d[idx], tag} || data_arr[idx] !== gl) begin
        n_err++; $display("FAIL rnd_line[%0d]: got tag %h expected %h", n, tag_arr[idx], {1'b1, ref_d[idx], tag}); end
    end
    mem_lat = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mem_lat = 0; stray_tok = 0;
    pl_en = 1'b0; pl_idx = '0; pl_tag = '0; pl_data = '0;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_MemWrite_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_req_drop();
    test_reset_mid_wb();
    test_stray_ack();
    test_random();
    n_cmp++; if (hold_viol !== 0) begin n_err++; $display("FAIL mem_hold: got %0d unstable cycles expected 0", hold_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst_i  in  1  reset, synchronous, active-low.
REQ-003 SHALL have CPU side: cpu_req_i in 1; cpu_addr_i in 32; cpu_data_i in 32; cpu_MemWrite_i in 1; cpu_data_o out 32; cpu_stall_o out 1.
REQ-004 SHALL have memory side: mem_enable_o out 1; mem_write_o out 1; mem_addr_o out 32; mem_data_o out 256; mem_data_i in 256; mem_ack_i in 1 (one-cycle pulse).
REQ-005 SHALL have tag-store side: sram_enable_o out 1; sram_addr_o out 4; sram_tag_o out 25; sram_data_o out 256; sram_write_o out 1; sram_hit_i in 1; sram_tag_i in 25; sram_data_i in 256.
REQ-006 SHALL split cpu_addr_i as tag [31:9] (23 b), index [8:5] (4 b), word [4:2], byte [1:0] ignored.
REQ-007 SHALL use tag format: [24] valid, [23] dirty, [22:0] tag.

Function
REQ-008 SHALL implement FSM states IDLE, MISS, WRITEBACK, READMISS, READMISSOK.
REQ-009 SHALL drive sram_addr_o = index and sram_enable_o = cpu_req_i in IDLE, and 1 in all other states.
REQ-010 IDLE read hit: cpu_data_o = word [word*32 +: 32] of sram_data_i, combinational in the same cycle; cpu_stall_o = 0.
REQ-011 IDLE write hit: same cycle, sram_write_o = 1; sram_data_o = sram_data_i with the selected word replaced by cpu_data_i; sram_tag_o = {1,1,tag}; cpu_stall_o = 0.
REQ-012 IDLE miss (cpu_req_i=1, sram_hit_i=0): cpu_stall_o = 1; next state MISS.
REQ-013 MISS, one cycle: go to WRITEBACK if sram_tag_i[24] and sram_tag_i[23] are both 1, else READMISS.
REQ-014 WRITEBACK: mem_enable_o = 1; mem_write_o = 1; mem_addr_o = {sram_tag_i[22:0], index, 5'b0}; mem_data_o = sram_data_i; all held stable until mem_ack_i; on ack go to READMISS.
REQ-015 READMISS: mem_enable_o = 1; mem_write_o = 0; mem_addr_o = {tag, index, 5'b0}; held until mem_ack_i.
REQ-016 READMISS on ack: in that same cycle, sram_write_o = 1, sram_data_o = mem_data_i, sram_tag_o = {1,0,tag}; next state READMISSOK.
REQ-017 READMISSOK: one cycle, stall held; next state IDLE. The request is re-evaluated in IDLE as a hit and served per REQ-010/011.
REQ-018 cpu_stall_o SHALL be 1 in every non-IDLE state.
REQ-019 mem_enable_o and sram_write_o SHALL be 0 except where stated.
REQ-020 mem_ack_i outside WRITEBACK/READMISS SHALL be ignored.
REQ-021 If cpu_req_i drops mid-miss, the controller SHALL still complete the line fill, then return to IDLE.
REQ-022 cpu_addr_i, cpu_data_i and cpu_MemWrite_i SHALL be held stable by the CPU while cpu_stall_o = 1; the controller does not latch them.
REQ-023 Miss-to-IDLE latency SHALL be 1 (MISS) + WB wait + fill wait + 1 (READMISSOK) cycles.

Reset
REQ-024 rst_i = 0 at a clock edge SHALL force IDLE from any state, including mid-handshake.
REQ-025 During reset, all outputs SHALL be 0: mem_enable_o, mem_write_o, sram_write_o, cpu_stall_o, and all data/address buses.
REQ-026 After reset, an in-flight mem_ack_i SHALL be ignored.

Structure
REQ-027 A shared package SHALL hold: state enum; TAG_W = 23; IDX_W = 4; LINE_W = 256; VALID_BIT = 24; DIRTY_BIT = 23; OFFSET_W = 5.
REQ-028 Word merge/select SHALL be one combinational sub-module, dcache_word_merge (line, word index, word in -> merged line, word out).
REQ-029 The FSM register SHALL be the only sequential state in the block.

Verification
REQ-030 Read hit: sram_hit_i = 1, word 3 of line = 32'hDEADBEEF, addr 0x0000_006C -> cpu_data_o = DEADBEEF, stall 0, no mem_enable_o.
REQ-031 Write hit: addr 0x0000_0020, data 32'h1234_5678 -> sram_write_o pulse; line word 0 = 12345678; sram_tag_o[24:23] = 2'b11.
REQ-032 Clean miss: victim tag 25'h0xxxxxx (valid=0) -> MISS, READMISS; mem_addr_o = {tag, idx, 00000}, mem_write_o = 0; ack after 10 cycles -> fill written with dirty = 0; stall released 2 cycles after ack.
REQ-033 Dirty miss: victim {1,1,23'h1} at index 2 -> WRITEBACK with mem_addr_o = 0x0000_0240 and mem_data_o = victim line; then READMISS; two mem transactions total.
REQ-034 Reset mid-WRITEBACK: rst_i low for 1 cycle -> next cycle IDLE; mem_enable_o = 0; a late mem_ack_i causes no SRAM write.
REQ-035 Stray mem_ack_i in IDLE with no request -> no state change; all outputs remain 0.
